// File: rtl/sddr_port_arbiter.sv
// ---------------------------------------------------------------------------
// sddr_port_arbiter
//
// Round-robin arbiter that shares the single SDDR controller data-command
// port among NUM_PORTS requesters. At most one transaction is outstanding at
// a time. Read responses are routed back to the port that issued the read.
// A watchdog delivers a zero-data response if the controller never answers.
//
// Ports:
//   cpu_clock_i         single clock
//   reset_n_i           asynchronous active-low reset
//   req_valid_i         per-port request valid, held until that port's ack
//   req_address_i       packed per-port byte addresses (port p at p*ADDRESS_BITS)
//   req_write_i         per-port write flag (1 = write)
//   req_data_i          packed per-port write data (port p at p*CMD_DATA_BITS)
//   req_ack_o           one-cycle command-accepted pulse, at most one bit set
//   rsp_ready_o         one-cycle read-data-valid pulse to the owning port
//   rsp_data_o          read data shared by all ports, qualified by rsp_ready_o
//   data_cmd_valid_o    command valid to the controller
//   data_cmd_address_o  command address to the controller
//   data_cmd_write_o    command write flag to the controller
//   data_cmd_data_o     command write data to the controller
//   data_cmd_ack_i      controller ready; transfer on valid && ack
//   data_rsp_ready_i    controller read-data pulse
//   data_rsp_data_i     controller read data
//   grant_o             currently or most recently granted port
//   busy_o              arbiter is not idle
//   err_timeout_o       sticky watchdog flag
//   err_clear_i         clears err_timeout_o (a simultaneous set wins)
//   stray_count_o       saturating count of responses received outside WAIT_RSP
// ---------------------------------------------------------------------------
module sddr_port_arbiter #(
  parameter int NUM_PORTS      = 3,
  parameter int ADDRESS_BITS   = 27,
  parameter int CMD_DATA_BITS  = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               cpu_clock_i,
  input  logic                               reset_n_i,
  input  logic [NUM_PORTS-1:0]               req_valid_i,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0]  req_address_i,
  input  logic [NUM_PORTS-1:0]               req_write_i,
  input  logic [NUM_PORTS*CMD_DATA_BITS-1:0] req_data_i,
  output logic [NUM_PORTS-1:0]               req_ack_o,
  output logic [NUM_PORTS-1:0]               rsp_ready_o,
  output logic [CMD_DATA_BITS-1:0]           rsp_data_o,
  output logic                               data_cmd_valid_o,
  output logic [ADDRESS_BITS-1:0]            data_cmd_address_o,
  output logic                               data_cmd_write_o,
  output logic [CMD_DATA_BITS-1:0]           data_cmd_data_o,
  input  logic                               data_cmd_ack_i,
  input  logic                               data_rsp_ready_i,
  input  logic [CMD_DATA_BITS-1:0]           data_rsp_data_i,
  output logic [$clog2(NUM_PORTS)-1:0]       grant_o,
  output logic                               busy_o,
  output logic                               err_timeout_o,
  input  logic                               err_clear_i,
  output logic [7:0]                         stray_count_o
);

  localparam int GW = $clog2(NUM_PORTS);
  // The timer only needs to reach TIMEOUT_CYCLES-1; one spare bit keeps the
  // width sane for tiny limits.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GW-1:0] LAST_PORT = GW'(NUM_PORTS - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [GW-1:0]            grant_q, grant_d;
  logic [GW-1:0]            last_grant_q, last_grant_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [NUM_PORTS-1:0]     rsp_ready_q, rsp_ready_d;
  logic [CMD_DATA_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                     err_q, err_d;
  logic [7:0]               stray_q, stray_d;

  logic [GW-1:0]            next_grant;
  logic [NUM_PORTS-1:0]     grant_onehot;
  logic                     sel_valid;
  logic                     sel_write;
  logic [ADDRESS_BITS-1:0]  sel_address;
  logic [CMD_DATA_BITS-1:0] sel_data;
  logic                     cmd_fire;
  logic                     err_set;

  // Round-robin search: walk offsets 1..NUM_PORTS from the last grant and take
  // the first requesting port. Offset NUM_PORTS lands on last_grant itself, so
  // a lone requester can be granted repeatedly.
  always_comb begin
    next_grant = last_grant_q;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (((int'(last_grant_q) + i) % NUM_PORTS) == p && req_valid_i[p]) begin
          next_grant = GW'(p);
        end
      end
    end
  end

  // Live mux of the granted port's request fields. A compare-per-port loop is
  // used instead of a variable index so non-power-of-two port counts never
  // select past the end of the packed buses.
  always_comb begin
    grant_onehot = '0;
    sel_valid    = 1'b0;
    sel_write    = 1'b0;
    sel_address  = '0;
    sel_data     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q == GW'(p)) begin
        grant_onehot[p] = 1'b1;
        sel_valid       = req_valid_i[p];
        sel_write       = req_write_i[p];
        sel_address     = req_address_i[p*ADDRESS_BITS +: ADDRESS_BITS];
        sel_data        = req_data_i[p*CMD_DATA_BITS +: CMD_DATA_BITS];
      end
    end
  end

  // The command is only presented while the granted port still requests, so a
  // port that withdraws early never has its command transferred.
  assign data_cmd_valid_o   = (state_q == ST_ISSUE) && sel_valid;
  assign data_cmd_address_o = sel_address;
  assign data_cmd_write_o   = sel_write;
  assign data_cmd_data_o    = sel_data;
  assign cmd_fire           = data_cmd_valid_o && data_cmd_ack_i;
  assign req_ack_o          = cmd_fire ? grant_onehot : '0;

  assign rsp_ready_o   = rsp_ready_q;
  assign rsp_data_o    = rsp_data_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign err_timeout_o = err_q;
  assign stray_count_o = stray_q;

  // Next-state logic for the transaction FSM, response path and error flags.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    rsp_ready_d  = '0;
    rsp_data_d   = rsp_data_q;
    err_d        = err_q;
    stray_d      = stray_q;
    err_set      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          grant_d      = next_grant;
          last_grant_d = next_grant;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!sel_valid) begin
          state_d = ST_IDLE;
        end else if (data_cmd_ack_i) begin
          if (sel_write) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RSP;
            timer_d = '0;
          end
        end
      end
      ST_WAIT_RSP: begin
        timer_d = timer_q + TW'(1);
        if (data_rsp_ready_i) begin
          rsp_data_d  = data_rsp_data_i;
          rsp_ready_d = grant_onehot;
          state_d     = ST_IDLE;
        end else if (WDOG_EN && (timer_q == TIMER_LAST)) begin
          // timer_q + 1 equals TIMEOUT_CYCLES on this cycle
          err_set     = 1'b1;
          rsp_data_d  = '0;
          rsp_ready_d = grant_onehot;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (data_rsp_ready_i && (state_q != ST_WAIT_RSP) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end

    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clear_i) begin
      err_d = 1'b0;
    end
  end

  // State registers. last_grant resets to the highest port so port 0 wins the
  // first arbitration.
  always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_PORT;
      timer_q      <= '0;
      rsp_ready_q  <= '0;
      rsp_data_q   <= '0;
      err_q        <= 1'b0;
      stray_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      rsp_ready_q  <= rsp_ready_d;
      rsp_data_q   <= rsp_data_d;
      err_q        <= err_d;
      stray_q      <= stray_d;
    end
  end

endmodule
